inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 redirect_valid  input  1  taken branch/jmp/jr/jal resolved this cycle.
REQ-006 redirect_pc  input  32  next-PC target; bits [1:0] ignored.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned read address; bits [1:0] always 00.
REQ-009 imem_ack  input  1  read data valid on imem_rdata; meaningful only while imem_req=1.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 inst_o  output  32  registered instruction to decode.
REQ-012 pc_o  output  32  address of inst_o.
REQ-013 pc_plus4_o  output  32  pc_o + 4, link value for jal.
REQ-014 inst_valid_o  output  1  inst_o/pc_o hold a live instruction.

Function
REQ-015 States SHALL be FETCH (request at fetch_pc) and DROP (old request outstanding, its response discarded).
REQ-016 imem_req SHALL be 1 in DROP, and 1 in FETCH when (inst_valid_o=0 or stall=0).
REQ-017 imem_addr SHALL come from a req_addr register that stays constant while imem_req=1 and imem_ack=0.
REQ-018 imem_ack may arrive in the request cycle (zero-wait memory) or any later cycle; no timeout.
REQ-019 FETCH with imem_req=1, imem_ack=1, redirect_valid=0: next cycle inst_o=imem_rdata, pc_o=fetch_pc, inst_valid_o=1, fetch_pc+=4.
REQ-020 inst_valid_o=1, stall=0, no new ack: inst_valid_o SHALL clear next cycle.
REQ-021 inst_valid_o=1, stall=1: inst_o, pc_o and inst_valid_o SHALL hold unchanged.
REQ-022 redirect_valid=1: fetch_pc SHALL load {redirect_pc[31:2],2'b00}, and inst_valid_o SHALL be 0 next cycle regardless of stall (redirect beats stall).
REQ-023 Redirect in FETCH, request outstanding, no ack: go to DROP and keep the old req_addr.
REQ-024 Redirect in FETCH with ack the same cycle: discard the data and stay in FETCH with the new fetch_pc.
REQ-025 DROP with imem_ack=1: discard data, go to FETCH; new fetch_pc is requested the following cycle.
REQ-026 Redirect while in DROP: update fetch_pc and stay in DROP.
REQ-027 fetch_pc SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag; pc_plus4_o wraps the same way.
REQ-028 Steady state with zero-wait memory and stall=0 SHALL be one instruction per cycle.

Reset
REQ-029 While rst=0: state=FETCH, fetch_pc=req_addr=RESET_PC, inst_o=0, pc_o=0, inst_valid_o=0, imem_req=0.
REQ-030 First rising edge after rst rises: imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset asserted mid-request abandons the request with no cleanup; the memory is reset on the same signal.

Structure
REQ-032 InstBus, InstAddrBus, RESET_PC default and the state encodings SHALL live in the shared defines.v.
REQ-033 The fetch_pc register, its +4 adder and the redirect mux SHALL be the sub-module pc_reg; FSM and output register stay in inst_fetch.

Verification
REQ-034 Reset release, zero-wait memory, stall=0 -> imem_addr 0,4,8,...; pc_o follows one cycle later; inst_valid_o=1 continuous.
REQ-035 stall=1 for 3 cycles with inst at pc 0x8 -> inst_o/pc_o stay 0x8, imem_req=0, no address advance; resumes at 0xC.
REQ-036 2-cycle-latency memory, redirect to 0x100 one cycle into the request for 0x10 -> DROP; 0x10 data discarded; next request 0x100; inst_valid_o=0 until 0x100 returns.
REQ-037 Redirect to 0x203 with stall=1 and inst_valid_o=1 -> inst_valid_o=0 next cycle; next imem_addr=0x200.
REQ-038 fetch_pc=0xFFFFFFFC -> pc_plus4_o=0; next imem_addr=0x0.
REQ-039 rst pulled low mid-request -> all outputs at reset values asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types, reset default and FSM encoding for the instruction fetch stage.
package inst_fetch_pkg;

    typedef logic [31:0] inst_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam inst_addr_bus_t RESET_PC_DEFAULT = 32'h0000_0000;

    // DROP: a request is still in flight to memory but its data is stale.
    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    function automatic inst_addr_bus_t word_align(input inst_addr_bus_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: redirect mux has priority over sequential +4 advance.
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_bus_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv_i,
    input  logic           redir_i,
    input  inst_addr_bus_t redir_pc_i,
    output inst_addr_bus_t pc_q_o,
    output inst_addr_bus_t pc_d_o
);

    inst_addr_bus_t pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redir_i)
            pc_d = word_align(redir_pc_i);
        else if (adv_i)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc_q <= word_align(RESET_PC);
        else
            pc_q <= pc_d;
    end

    assign pc_q_o = pc_q;
    assign pc_d_o = pc_d;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word reads, drops stale responses after a redirect,
// and holds one registered instruction for decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_bus_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        inst_valid_o
);

    fetch_state_e   state_q, state_d;
    logic           run_q;
    inst_addr_bus_t req_addr_q, req_addr_d;
    inst_addr_bus_t fetch_pc_q, fetch_pc_d;
    inst_bus_t      inst_q, inst_d;
    inst_addr_bus_t pc_q, pc_d;
    logic           valid_q, valid_d;
    logic           ack, accept;

    // run_q keeps the request low until the first edge after reset release.
    assign imem_req = run_q && ((state_q == DROP) || !valid_q || !stall);
    assign ack      = imem_req && imem_ack;
    assign accept   = (state_q == FETCH) && ack && !redirect_valid;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (accept),
        .redir_i    (redirect_valid),
        .redir_pc_i (redirect_pc),
        .pc_q_o     (fetch_pc_q),
        .pc_d_o     (fetch_pc_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (redirect_valid && imem_req && !imem_ack) state_d = DROP;
            DROP:  if (ack) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // While a stale request is in flight its address must stay on the bus.
        req_addr_d = (state_d == FETCH) ? fetch_pc_d : req_addr_q;

        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q && stall && !redirect_valid;
        if (accept) begin
            inst_d  = imem_rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            run_q      <= 1'b0;
            req_addr_q <= word_align(RESET_PC);
            inst_q     <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr    = req_addr_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + 32'd4;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, hand-written corner sequences,
// and a randomized run checked against an instruction-stream model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        inst_valid_o;

    int n_chk  = 0;
    int n_pass = 0;

    // memory model controls
    int          lat       = 0;
    logic        rand_mode = 1'b0;
    logic        ack_rnd   = 1'b0;
    int          wcnt;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb begin
        imem_ack   = imem_req && (rand_mode ? ack_rnd : (wcnt >= lat));
        imem_rdata = memf(imem_addr);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst)
            wcnt <= 0;
        else if (imem_req && !imem_ack)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[14];

    // random-phase model state
    logic [31:0] exp_pc, prev_addr, prev_pc, prev_inst;
    logic        prev_pend, prev_redir, prev_hold;
    int          n_cons;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h4};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h8};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h8};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h8};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h8};
        tbl[8]  = '{1'b1, 1'b1, 32'h203,      1'b0, 32'h10,       1'b1, 32'hC};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'hC};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h204,      1'b1, 32'h200};
        tbl[11] = '{1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h208,      1'b1, 32'h204};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 32'h204};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFFFFFC};

        // ---- reset state ----
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req",   imem_req,     0);
        chk("rst_addr",  imem_addr,    32'h0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_pc",    pc_o,         32'h0);
        chk("rst_inst",  inst_o,       32'h0);

        // ---- directed table, zero-wait memory ----
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            if (i == 0) rst = 1'b1;
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("tbl%0d_req", i),   imem_req,     tbl[i].exp_req);
            chk($sformatf("tbl%0d_addr", i),  imem_addr,    tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), inst_valid_o, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_pc", i),    pc_o,         tbl[i].exp_pc);
            chk($sformatf("tbl%0d_plus4", i), pc_plus4_o,   tbl[i].exp_pc + 32'd4);
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_inst", i), inst_o, memf(tbl[i].exp_pc));
        end

        // ---- redirect during a slow request goes through DROP ----
        lat = 0;
        do_reset();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        chk("drop_c0_addr", imem_addr, 32'h0);
        @(posedge clk); #1 lat = 2;
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("drop_c1_addr",  imem_addr,    32'h10);
        chk("drop_c1_valid", inst_valid_o, 0);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        chk("drop_c2_addr", imem_addr, 32'h10);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("drop_c3_req",   imem_req,     1);
        chk("drop_c3_addr",  imem_addr,    32'h10);
        chk("drop_c3_valid", inst_valid_o, 0);
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk); #1;
            chk($sformatf("drop_c%0d_addr", c),  imem_addr,    32'h100);
            chk($sformatf("drop_c%0d_valid", c), inst_valid_o, 0);
        end
        @(negedge clk); #1;
        chk("drop_c7_valid", inst_valid_o, 1);
        chk("drop_c7_pc",    pc_o,         32'h100);
        chk("drop_c7_inst",  inst_o,       memf(32'h100));

        // ---- asynchronous reset in the middle of a request ----
        lat = 5;
        @(negedge clk); #2 rst = 1'b0; #1;
        chk("arst_req",   imem_req,     0);
        chk("arst_valid", inst_valid_o, 0);
        chk("arst_pc",    pc_o,         32'h0);
        chk("arst_inst",  inst_o,       32'h0);
        chk("arst_addr",  imem_addr,    32'h0);
        lat = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_req",  imem_req,  1);
        chk("arst_rel_addr", imem_addr, 32'h0);

        // ---- randomized run vs instruction-stream model ----
        rand_mode = 1'b1;
        do_reset();
        exp_pc = 32'h0; prev_pend = 1'b0; prev_redir = 1'b0; prev_hold = 1'b0;
        prev_addr = 32'h0; prev_pc = 32'h0; prev_inst = 32'h0; n_cons = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 4095));
            ack_rnd        = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (prev_pend) begin
                chk("rnd_req_held",  imem_req,  1);
                chk("rnd_addr_held", imem_addr, prev_addr);
            end
            if (prev_redir) chk("rnd_redir_kill", inst_valid_o, 0);
            if (prev_hold) begin
                chk("rnd_stall_valid", inst_valid_o, 1);
                chk("rnd_stall_pc",    pc_o,         prev_pc);
                chk("rnd_stall_inst",  inst_o,       prev_inst);
            end
            if (inst_valid_o) begin
                chk("rnd_pc",    pc_o,       exp_pc);
                chk("rnd_inst",  inst_o,     memf(exp_pc));
                chk("rnd_plus4", pc_plus4_o, exp_pc + 32'd4);
            end
            prev_pend  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            prev_redir = redirect_valid;
            prev_hold  = inst_valid_o && stall && !redirect_valid;
            prev_pc    = pc_o;
            prev_inst  = inst_o;
            if (inst_valid_o && !stall) begin
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        end
        chk("rnd_throughput", {31'b0, n_cons > 300}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
